// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/bubble controller for the 5-stage MIPS pipeline.
// Compares D-stage Tuse against E/M Tnew, tracks HI/LO busy, counts stalls.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   d_rs/d_rt           D-stage source register numbers
//   d_use_rs/d_use_rt   D instruction reads rs / rt
//   d_tuse_rs/_rt       cycles until the operand is consumed (0..2)
//   d_md_op             D instruction touches the MD unit or HI/LO
//   e_wa, e_tnew        E-stage destination and cycles until ready
//   m_wa, m_tnew        M-stage destination and cycles until ready
//   e_md_start          E instruction starts a mult/div
//   e_md_is_div         that start is a divide
//   stall_fd            hold PC and IF/ID
//   flush_de            bubble into E through the ID/EX pause input
//   md_busy             MD unit still computing
//   stall_cnt           saturating count of stall cycles since reset

module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        d_rs,
    input  logic [4:0]        d_rt,
    input  logic              d_use_rs,
    input  logic              d_use_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic              d_md_op,
    input  logic [4:0]        e_wa,
    input  logic [1:0]        e_tnew,
    input  logic [4:0]        m_wa,
    input  logic [1:0]        m_tnew,
    input  logic              e_md_start,
    input  logic              e_md_is_div,
    output logic              stall_fd,
    output logic              flush_de,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    logic [CNT_W-1:0] md_cnt;
    logic             rs_e;
    logic             rs_m;
    logic             rt_e;
    logic             rt_m;
    logic             md_stall;
    logic             stall;

    // A producer only matters if its value is still not ready
    // by the time the consumer needs it (Tuse < Tnew).
    always_comb begin
        rs_e = d_use_rs && (d_rs != 5'd0) && (d_rs == e_wa)
               && (d_tuse_rs < e_tnew);
        rs_m = d_use_rs && (d_rs != 5'd0) && (d_rs == m_wa)
               && (d_tuse_rs < m_tnew);
        rt_e = d_use_rt && (d_rt != 5'd0) && (d_rt == e_wa)
               && (d_tuse_rt < e_tnew);
        rt_m = d_use_rt && (d_rt != 5'd0) && (d_rt == m_wa)
               && (d_tuse_rt < m_tnew);
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = d_md_op && (e_md_start || md_busy);

    // Gated by reset so the pipeline sees no stall while held in reset.
    assign stall    = reset && (rs_e || rs_m || rt_e || rt_m || md_stall);
    assign stall_fd = stall;
    assign flush_de = stall;

    // A start in E is real even while D is stalled, so it always loads;
    // a start while busy simply restarts the countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (e_md_start) begin
            md_cnt <= e_md_is_div ? CNT_W'(DIV_CYCLES)
                                  : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl.
// Second instance with a 4-bit perf counter covers saturation.

module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic        d_use_rs, d_use_rt, d_md_op;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        e_md_start, e_md_is_div;
    logic        stall_fd, flush_de, md_busy;
    logic [31:0] stall_cnt;
    logic        s_stall_fd, s_flush_de, s_md_busy;
    logic [3:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_md_op(d_md_op),
        .e_wa(e_wa), .e_tnew(e_tnew),
        .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .stall_fd(stall_fd), .flush_de(flush_de),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.PERF_W(4)) sat (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_md_op(d_md_op),
        .e_wa(e_wa), .e_tnew(e_tnew),
        .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .stall_fd(s_stall_fd), .flush_de(s_flush_de),
        .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
        d_tuse_rs = 0; d_tuse_rt = 0; d_md_op = 0;
        e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
        e_md_start = 0; e_md_is_div = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12;
        chk("rst_stall", {31'd0, stall_fd}, 0);
        chk("rst_busy", {31'd0, md_busy}, 0);
        chk("rst_cnt", stall_cnt, 0);
        reset = 1'b1;
        step();

        // Load-use from E, then same producer in M, then ready.
        d_rs = 8; d_use_rs = 1; d_tuse_rs = 0;
        e_wa = 8; e_tnew = 2;
        #1;
        chk("lu_e_stall", {31'd0, stall_fd}, 1);
        chk("lu_e_flush", {31'd0, flush_de}, 1);
        step();
        e_wa = 0; e_tnew = 0; m_wa = 8; m_tnew = 1;
        #1;
        chk("lu_m_stall", {31'd0, stall_fd}, 1);
        step();
        m_tnew = 0;
        #1;
        chk("lu_m_ready", {31'd0, stall_fd}, 0);
        chk("lu_cnt", stall_cnt, 2);

        // rt path: Tuse 1 < Tnew 2 stalls, Tuse 1 vs Tnew 1 does not.
        idle();
        d_rt = 9; d_use_rt = 1; d_tuse_rt = 1; e_wa = 9; e_tnew = 2;
        #1;
        chk("rt_e", {31'd0, stall_fd}, 1);
        e_wa = 0; e_tnew = 0; m_wa = 9; m_tnew = 1;
        #1;
        chk("rt_m_eq", {31'd0, stall_fd}, 0);

        // Zero register never stalls.
        idle();
        d_rt = 0; d_use_rt = 1; d_tuse_rt = 0; e_wa = 0; e_tnew = 2;
        #1;
        chk("zero_reg", {31'd0, stall_fd}, 0);
        // Equal Tuse/Tnew = 2.
        idle();
        d_rs = 5; d_use_rs = 1; d_tuse_rs = 2; e_wa = 5; e_tnew = 2;
        #1;
        chk("tuse_eq", {31'd0, stall_fd}, 0);
        // Tnew 0 never stalls.
        d_tuse_rs = 0; e_tnew = 0;
        #1;
        chk("tnew0", {31'd0, stall_fd}, 0);
        // Unused operand never stalls.
        d_use_rs = 0; e_tnew = 2;
        #1;
        chk("no_use", {31'd0, stall_fd}, 0);

        // Mult then mflo held in D: 1 start cycle + 5 busy cycles.
        do_reset();
        e_md_start = 1; e_md_is_div = 0; d_md_op = 1;
        #1;
        chk("mul_start", {31'd0, stall_fd}, 1);
        step();
        e_md_start = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mul_busy%0d", i), {31'd0, md_busy}, 1);
            chk($sformatf("mul_stall%0d", i), {31'd0, stall_fd}, 1);
            step();
        end
        chk("mul_done_busy", {31'd0, md_busy}, 0);
        chk("mul_done_stall", {31'd0, stall_fd}, 0);
        chk("mul_cnt", stall_cnt, 6);

        // Combined data + MD hazard counts once per cycle.
        do_reset();
        d_md_op = 1; e_md_start = 1;
        d_rs = 3; d_use_rs = 1; e_wa = 3; e_tnew = 2;
        #1;
        chk("both_stall", {31'd0, stall_fd}, 1);
        step();
        idle();
        #1;
        chk("both_cnt", stall_cnt, 1);

        // Div, 3 busy cycles, then mult restart reloads to 5.
        do_reset();
        e_md_start = 1; e_md_is_div = 1;
        step();
        e_md_start = 0; e_md_is_div = 0;
        step();
        step();
        chk("div_busy", {31'd0, md_busy}, 1);
        e_md_start = 1;
        step();
        e_md_start = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("reload_busy%0d", i), {31'd0, md_busy}, 1);
            step();
        end
        chk("reload_done", {31'd0, md_busy}, 0);
        chk("reload_cnt", stall_cnt, 0);

        // Async reset mid-divide with mfhi waiting in D.
        do_reset();
        e_md_start = 1; e_md_is_div = 1; d_md_op = 1;
        step();
        e_md_start = 0; e_md_is_div = 0;
        step();
        step();
        step();
        chk("ar_pre_cnt", stall_cnt, 4);
        chk("ar_pre_busy", {31'd0, md_busy}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_busy", {31'd0, md_busy}, 0);
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_stall", {31'd0, stall_fd}, 0);
        #1;
        reset = 1'b1;
        step();
        chk("ar_post_busy", {31'd0, md_busy}, 0);
        chk("ar_post_stall", {31'd0, stall_fd}, 0);
        chk("ar_post_cnt", stall_cnt, 0);

        // Saturation on the 4-bit perf counter.
        do_reset();
        d_rs = 8; d_use_rs = 1; d_tuse_rs = 0; e_wa = 8; e_tnew = 2;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt4", {28'd0, s_stall_cnt}, 15);
        chk("sat_cnt32", stall_cnt, 20);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
